cordic_cos_scheduler: RTL and testbench

Shares one iterative CORDIC cosine core between `N_REQ` requesters. A round-robin arbiter selects one pending angle and drives it into the core. The block waits for the core's `done`, then returns the 22-bit cosine tagged with the requester ID through a single valid/ready response port. It sits between the floating-point front-end request queues and the cosine core, so the core's `clk_en`/`done` protocol stays hidden from clients.

---
 rtl/cordic_sched_pkg.sv | 16 +
 rtl/cordic_rr_arbiter.sv | 43 ++++
 rtl/cordic_cos_scheduler.sv | 158 +++++++++++++++
 tb/tb_cordic_cos_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sched_pkg.sv
// Purpose: shared constants and FSM state type for the CORDIC cosine scheduler.
// Contents: CORDIC_W (angle/cosine width), TIMEOUT_DEFAULT (watchdog limit),
//           sched_state_t (IDLE/ISSUE/WAIT/RESP).
package cordic_sched_pkg;

  localparam int unsigned CORDIC_W        = 22;
  localparam int unsigned TIMEOUT_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Purpose: combinational round-robin grant. Picks the first asserted request
//          at or after i_ptr, searching upward with wrap.
// Ports:
//   i_req   - request vector
//   i_ptr   - round-robin start position
//   i_en    - grant enable; no grant when low
//   o_grant - one-hot grant
//   o_idx   - encoded index of the grant
//   o_valid - a grant was made
module cordic_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  localparam int unsigned SW = ID_W + 1;

  logic [SW-1:0] w_sum;

  // Walk positions ptr, ptr+1, ... (mod N_REQ); the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + SW'(i);
      if (w_sum >= SW'(N_REQ)) w_sum = w_sum - SW'(N_REQ);
      if (i_en && !o_valid && i_req[w_sum[ID_W-1:0]]) begin
        o_valid                   = 1'b1;
        o_idx                     = w_sum[ID_W-1:0];
        o_grant[w_sum[ID_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_cos_scheduler.sv
// Purpose: shares one iterative CORDIC cosine core between N_REQ requesters.
//          Round-robin grant, one core job at a time, result returned with the
//          requester ID through a single valid/ready response port.
// Optional feature: define CORDIC_SCHED_WATCHDOG_EN to abort core jobs that do
//          not finish within TIMEOUT cycles (resp_err=1, resp_cos=0).
// Ports:
//   clk, reset               - clock, async active-high reset
//   req_valid/req_angle      - per-requester request and packed 22-bit angles
//   req_ready                - one-hot grant pulse (combinational, IDLE only)
//   resp_valid/resp_ready    - response handshake
//   resp_id/resp_cos/resp_err- response payload
//   core_reset/core_clk_en   - core synchronous reset and start pulse
//   core_angle               - angle presented to the core
//   core_cos/core_done       - core result and completion
module cordic_cos_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = $clog2(N_REQ),
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*CORDIC_W-1:0] req_angle,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [CORDIC_W-1:0]       resp_cos,
  output logic                      resp_err,
  output logic                      core_reset,
  output logic                      core_clk_en,
  output logic [CORDIC_W-1:0]       core_angle,
  input  logic [CORDIC_W-1:0]       core_cos,
  input  logic                      core_done
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("cordic_cos_scheduler: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  sched_state_t          r_state, w_next_state;
  logic [ID_W-1:0]       r_rr_ptr, r_id, w_idx, w_ptr_next;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_gnt_valid;
  logic [CORDIC_W-1:0]   r_angle, r_cos, w_sel_angle;
  logic                  r_rst_hold;
  logic                  w_wd_abort;
  logic                  w_wd_pulse;

  cordic_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (r_state == S_IDLE),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_gnt_valid)
  );

  // Angle of the granted requester.
  always_comb begin
    w_sel_angle = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_idx == ID_W'(k)) w_sel_angle = req_angle[k*CORDIC_W +: CORDIC_W];
    end
  end

  assign w_ptr_next = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (core_done || w_wd_abort) w_next_state = S_RESP;
      S_RESP:  if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant bookkeeping and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_angle  <= '0;
      r_cos    <= '0;
    end else begin
      if (r_state == S_IDLE && w_gnt_valid) begin
        r_rr_ptr <= w_ptr_next;
        r_id     <= w_idx;
        r_angle  <= w_sel_angle;
      end
      if (r_state == S_WAIT) begin
        if (core_done)       r_cos <= core_cos;
        else if (w_wd_abort) r_cos <= '0;
      end
    end
  end

  // Stretch core reset by one registered cycle so the core's sync reset is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rst_hold <= 1'b1;
    else       r_rst_hold <= 1'b0;
  end

`ifdef CORDIC_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_pulse;
  logic            r_err;

  // Abort on the TIMEOUT-th WAIT cycle without core_done.
  assign w_wd_abort = (r_state == S_WAIT) && !core_done &&
                      (r_wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt   <= '0;
      r_wd_pulse <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wd_pulse <= w_wd_abort;
      r_wd_cnt   <= (r_state == S_WAIT) ? r_wd_cnt + WD_W'(1) : '0;
      if (w_wd_abort)                         r_err <= 1'b1;
      else if (r_state == S_RESP && resp_ready) r_err <= 1'b0;
    end
  end

  assign w_wd_pulse = r_wd_pulse;
  assign resp_err   = r_err;
`else
  assign w_wd_abort = 1'b0;
  assign w_wd_pulse = 1'b0;
  assign resp_err   = 1'b0;
`endif

  assign req_ready   = w_grant;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_id;
  assign resp_cos    = r_cos;
  assign core_clk_en = (r_state == S_ISSUE);
  assign core_angle  = r_angle;
  assign core_reset  = reset | r_rst_hold | w_wd_pulse;

endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// Purpose: self-checking bench for cordic_cos_scheduler. A transaction-level
//          reference (round-robin pointer, in-flight job, cosine = ~angle)
//          predicts grants and responses; a core model returns ~angle after a
//          configurable latency. With CORDIC_SCHED_WATCHDOG_EN the watchdog
//          abort path is exercised as well.
module tb_cordic_cos_scheduler;

  localparam int N  = 4;
  localparam int W  = 22;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_angle;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [1:0]       resp_id;
  logic [W-1:0]     resp_cos;
  logic             resp_err;
  logic             core_reset;
  logic             core_clk_en;
  logic [W-1:0]     core_angle;
  logic [W-1:0]     core_cos;
  logic             core_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_cos_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_cos    (resp_cos),
    .resp_err    (resp_err),
    .core_reset  (core_reset),
    .core_clk_en (core_clk_en),
    .core_angle  (core_angle),
    .core_cos    (core_cos),
    .core_done   (core_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Core model: result ~angle, done pulse lat cycles after the start pulse.
  int           lat    = 5;
  bit           c_hang = 1'b0;
  bit           c_busy = 1'b0;
  int           c_rem  = 0;
  logic [W-1:0] c_cos_r = '0;
  assign core_cos = c_cos_r;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_reset) begin
      c_busy <= 1'b0;
    end else if (core_clk_en) begin
      c_cos_r <= ~core_angle;
      if (lat <= 1) core_done <= 1'b1;
      else begin
        c_rem  <= lat - 1;
        c_busy <= 1'b1;
      end
    end else if (c_busy && !c_hang) begin
      if (c_rem == 1) begin
        core_done <= 1'b1;
        c_busy    <= 1'b0;
      end
      c_rem <= c_rem - 1;
    end
  end

  // Reference model of the scheduler, checked every cycle mid-period.
  bit           m_chk_en = 1'b1;
  bit           m_busy   = 1'b0;
  bit           m_done   = 1'b0;
  int           m_ptr    = 0;
  int           m_id     = 0;
  int           m_gcyc   = 0;
  int           m_dcyc   = 0;
  logic [W-1:0] m_angle  = '0;
  logic [W-1:0] m_cos;
  logic [N-1:0] exp_g;
  int           gi;
  bit           exp_rv;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ptr  = 0;
    end else if (m_chk_en) begin
      exp_g = '0;
      gi    = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (gi < 0 && req_valid[(m_ptr + i) % N]) gi = (m_ptr + i) % N;
        end
        if (gi >= 0) exp_g[gi] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_g));
      check("core_clk_en", 32'(core_clk_en), 32'(m_busy && cyc == m_gcyc + 1));
      if (m_busy && cyc > m_gcyc && !m_done)
        check("core_angle", 32'(core_angle), 32'(m_angle));
      exp_rv = m_busy && m_done && cyc > m_dcyc;
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        m_cos = ~m_angle;
        check("resp_id", 32'(resp_id), 32'(m_id));
        check("resp_cos", 32'(resp_cos), 32'(m_cos));
        check("resp_err", 32'(resp_err), 32'd0);
      end
      if (gi >= 0) begin
        m_busy  = 1'b1;
        m_done  = 1'b0;
        m_id    = gi;
        m_angle = req_angle[gi*W +: W];
        m_gcyc  = cyc;
        m_ptr   = (gi + 1) % N;
      end else if (m_busy && !m_done && cyc >= m_gcyc + 2 && core_done) begin
        m_done = 1'b1;
        m_dcyc = cyc;
      end else if (exp_rv && resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g, output int gc);
    bit got = 1'b0;
    g  = -1;
    gc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        got = 1'b1;
        gc  = cyc;
        for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
      end
    end
    if (!got) check("grant_timeout", 32'(got), 32'd1);
    step();
  endtask

  task automatic wait_resp(output int rc);
    bit got = 1'b0;
    rc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        rc  = cyc;
      end
    end
    if (!got) check("resp_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      step();
      idle = !m_busy;
    end
    if (!idle) check("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int           g, gc, rc;
    logic [W-1:0] a, ec;
    bit           saw_rst;

    reset      = 1'b1;
    req_valid  = '0;
    req_angle  = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_cos", 32'(resp_cos), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_core_clk_en", 32'(core_clk_en), 32'd0);
    check("rst_core_angle", 32'(core_angle), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hold_hi", 32'(core_reset), 32'd1);
    @(negedge clk);
    check("rst_hold_lo", 32'(core_reset), 32'd0);
    step();

    // Fairness: all requesters valid.
    for (int k = 0; k < N; k++) req_angle[k*W +: W] = W'($urandom);
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      wait_grant(g, gc);
      check("rr_order", 32'(g), 32'(t % N));
    end
    req_valid = '0;
    wait_idle();

    // Single request with the reference angle.
    req_angle[2*W +: W] = 22'h0C90FD;
    req_valid = 4'b0100;
    wait_grant(g, gc);
    req_valid = '0;
    check("single_gnt", 32'(g), 32'd2);
    check("single_issue", 32'(core_clk_en), 32'd1);
    wait_resp(rc);
    check("single_lat", 32'(rc - gc), 32'd7);
    check("single_id", 32'(resp_id), 32'd2);
    check("single_cos", 32'(resp_cos), 32'h336F02);
    wait_idle();

    // Pointer at 3, only requester 1 valid.
    req_valid = 4'b0010;
    wait_grant(g, gc);
    req_valid = '0;
    check("wrap_gnt", 32'(g), 32'd1);
    wait_idle();
    req_valid = '1;
    wait_grant(g, gc);
    check("wrap_ptr", 32'(g), 32'd2);

    // Backpressure on the response.
    resp_ready = 1'b0;
    wait_resp(rc);
    ec = ~req_angle[2*W +: W];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd2);
      check("bp_cos", 32'(resp_cos), 32'(ec));
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    step();
    resp_ready = 1'b1;
    req_valid  = '0;
    wait_idle();

    // Reset in the middle of WAIT.
    req_angle[0 +: W] = W'($urandom) | 22'h1;
    req_valid = 4'b0001;
    wait_grant(g, gc);
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_clk_en", 32'(core_clk_en), 32'd0);
    check("mid_rst_angle", 32'(core_angle), 32'd0);
    check("mid_rst_resp_cos", 32'(resp_cos), 32'd0);
    check("mid_rst_resp_id", 32'(resp_id), 32'd0);
    check("mid_rst_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_hold_hi", 32'(core_reset), 32'd1);
    @(negedge clk);
    check("mid_rst_hold_lo", 32'(core_reset), 32'd0);
    step();
    req_valid = '1;
    wait_grant(g, gc);
    check("mid_rst_ptr", 32'(g), 32'd0);
    req_valid = '0;
    wait_idle();

    // Randomized traffic with varying core latency.
    for (int chunk = 0; chunk < 6; chunk++) begin
      lat = $urandom_range(1, 9);
      for (int c = 0; c < 300; c++) begin
        step();
        for (int k = 0; k < N; k++) begin
          if (req_valid[k]) begin
            if ($urandom_range(0, 7) == 0) req_valid[k] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            req_angle[k*W +: W] = W'($urandom);
            req_valid[k] = 1'b1;
          end
        end
        resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    lat        = 5;
    wait_idle();

`ifdef CORDIC_SCHED_WATCHDOG_EN
    // Core never completes: watchdog abort, then a normal job.
    m_chk_en = 1'b0;
    c_hang   = 1'b1;
    req_angle[3*W +: W] = W'($urandom) | 22'h1;
    req_valid = 4'b1000;
    wait_grant(g, gc);
    req_valid = '0;
    check("wd_gnt", 32'(g), 32'd3);
    saw_rst = 1'b0;
    rc = 0;
    for (int i = 0; i < 40 && rc == 0; i++) begin
      @(negedge clk);
      if (core_reset) saw_rst = 1'b1;
      if (resp_valid) rc = cyc;
    end
    check("wd_lat", 32'(rc - gc), 32'(TO + 2));
    check("wd_core_reset", 32'(saw_rst), 32'd1);
    check("wd_err", 32'(resp_err), 32'd1);
    check("wd_cos", 32'(resp_cos), 32'd0);
    step();
    check("wd_err_clear", 32'(resp_err), 32'd0);
    check("wd_resp_done", 32'(resp_valid), 32'd0);
    c_hang   = 1'b0;
    m_busy   = 1'b0;
    m_ptr    = 0;
    m_chk_en = 1'b1;
    a = W'($urandom);
    req_angle[1*W +: W] = a;
    req_valid = 4'b0010;
    wait_grant(g, gc);
    req_valid = '0;
    wait_resp(rc);
    ec = ~a;
    check("wd_next_err", 32'(resp_err), 32'd0);
    check("wd_next_cos", 32'(resp_cos), 32'(ec));
    wait_idle();
`else
    a = '0;
    saw_rst = 1'b0;
    if (a != 0 || saw_rst) ec = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
